// File: rtl/ted_ml_avg_if.sv
// Sample/result bundle for ted_ml_avg.
// master: sample source and result sink; slave: the detector itself.
interface ted_ml_avg_if #(
    parameter int NB_INPUT  = 9,
    parameter int NB_OUTPUT = 20
);
    logic                        enable_ted;
    logic                        i_mode;
    logic signed [NB_INPUT-1:0]  rx_output;
    logic signed [NB_INPUT-1:0]  phase_behind;
    logic signed [NB_INPUT-1:0]  phase_forward;
    logic signed [NB_INPUT-1:0]  o_data;
    logic                        o_data_valid;
    logic signed [NB_OUTPUT-1:0] o_ted;
    logic                        o_ted_valid;
    logic                        o_sat;

    modport master (
        output enable_ted, i_mode, rx_output, phase_behind, phase_forward,
        input  o_data, o_data_valid, o_ted, o_ted_valid, o_sat
    );

    modport slave (
        input  enable_ted, i_mode, rx_output, phase_behind, phase_forward,
        output o_data, o_data_valid, o_ted, o_ted_valid, o_sat
    );
endinterface

// File: rtl/ted_ml_avg.sv
// Pipelined ML / sign-ML timing error detector with integrate-and-dump averaging.
// Stage 1 registers diff and rx, stage 2 the product, stage 3 accumulates and
// dumps one rounded/saturated average every 2^LOG2_AVG valid products.
// Optional macro TED_ML_AVG_ROUND_EN: round half-up when dropping fraction bits
// (default: truncate toward -inf).
// rst_n is a synchronous, active-HIGH reset despite its name.
module ted_ml_avg #(
    parameter int NB_INPUT   = 9,
    parameter int NBF_INPUT  = 7,
    parameter int NB_OUTPUT  = 20,
    parameter int NBF_OUTPUT = 15,
    parameter int LOG2_AVG   = 2
) (
    input logic          clk,
    input logic          rst_n,
    ted_ml_avg_if.slave  bus_io
);
    localparam int NB_DIFF  = NB_INPUT + 1;
    localparam int NB_PROD  = 2 * NB_INPUT + 1;
    localparam int NB_ACC   = NB_PROD + LOG2_AVG;
    localparam int NBF_SUM  = 2 * NBF_INPUT + LOG2_AVG;
    localparam int SHL      = (NBF_OUTPUT > NBF_SUM) ? NBF_OUTPUT - NBF_SUM : 0;
    localparam int SHR      = (NBF_SUM > NBF_OUTPUT) ? NBF_SUM - NBF_OUTPUT : 0;
    // One spare bit so the rounding add cannot wrap before saturation.
    localparam int NB_W_RAW = NB_ACC + SHL + 1;
    localparam int NB_W     = (NB_W_RAW > NB_OUTPUT + 1) ? NB_W_RAW : NB_OUTPUT + 1;
    localparam int NB_CNT   = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'((2 ** LOG2_AVG) - 1);

`ifdef TED_ML_AVG_ROUND_EN
    localparam logic signed [NB_W-1:0] RND = NB_W'((2 ** SHR) / 2);
`else
    localparam logic signed [NB_W-1:0] RND = '0;
`endif

    localparam logic signed [NB_W-1:0] OUT_MAX =
        {{(NB_W - NB_OUTPUT + 1){1'b0}}, {(NB_OUTPUT - 1){1'b1}}};
    localparam logic signed [NB_W-1:0] OUT_MIN =
        {{(NB_W - NB_OUTPUT + 1){1'b1}}, {(NB_OUTPUT - 1){1'b0}}};

    logic                        s1_valid_q;
    logic                        s1_mode_q;
    logic signed [NB_DIFF-1:0]   s1_diff_q;
    logic signed [NB_INPUT-1:0]  s1_rx_q;

    logic signed [NB_PROD-1:0]   prod_d;
    logic signed [NB_PROD-1:0]   shifted;
    logic                        s2_valid_q;
    logic signed [NB_PROD-1:0]   s2_prod_q;

    logic signed [NB_ACC-1:0]    acc_q;
    logic [NB_CNT-1:0]           cnt_q;
    logic signed [NB_ACC-1:0]    sum;
    logic signed [NB_W-1:0]      sum_w;
    logic signed [NB_W-1:0]      conv;
    logic                        last;
    logic                        sat_d;
    logic signed [NB_OUTPUT-1:0] ted_d;
    logic signed [NB_OUTPUT-1:0] ted_q;
    logic                        ted_valid_q;
    logic                        sat_q;

    // Stage 1: capture sample, early-minus-late difference and mode.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_diff_q  <= '0;
            s1_rx_q    <= '0;
        end else begin
            s1_valid_q <= bus_io.enable_ted;
            if (bus_io.enable_ted) begin
                s1_mode_q <= bus_io.i_mode;
                s1_rx_q   <= bus_io.rx_output;
                s1_diff_q <= {bus_io.phase_forward[NB_INPUT-1], bus_io.phase_forward}
                           - {bus_io.phase_behind[NB_INPUT-1], bus_io.phase_behind};
            end
        end
    end

    // Error law: full product, or +/-diff aligned to the product's binary point.
    always_comb begin
        shifted = NB_PROD'(s1_diff_q) <<< NBF_INPUT;
        prod_d  = NB_PROD'(s1_rx_q) * NB_PROD'(s1_diff_q);
        if (s1_mode_q) begin
            prod_d = s1_rx_q[NB_INPUT-1] ? -shifted : shifted;
        end
    end

    // Stage 2: register the product.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_q <= prod_d;
            end
        end
    end

    // Window sum, reinterpreted as the average, rescaled and saturated.
    always_comb begin
        sum   = acc_q + NB_ACC'(s2_prod_q);
        sum_w = (NB_W'(sum) + RND) >>> SHR;
        conv  = sum_w <<< SHL;
        last  = s2_valid_q && (cnt_q == CNT_LAST);
        sat_d = 1'b0;
        ted_d = conv[NB_OUTPUT-1:0];
        if (conv > OUT_MAX) begin
            sat_d = 1'b1;
            ted_d = OUT_MAX[NB_OUTPUT-1:0];
        end else if (conv < OUT_MIN) begin
            sat_d = 1'b1;
            ted_d = OUT_MIN[NB_OUTPUT-1:0];
        end
    end

    // Stage 3: integrate, and dump on the last product of each window.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ted_q       <= '0;
            ted_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            ted_valid_q <= 1'b0;
            if (last) begin
                acc_q       <= '0;
                cnt_q       <= '0;
                ted_q       <= ted_d;
                sat_q       <= sat_d;
                ted_valid_q <= 1'b1;
            end else if (s2_valid_q) begin
                acc_q <= sum;
                cnt_q <= cnt_q + NB_CNT'(1);
            end
        end
    end

    // Outputs.
    always_comb begin
        bus_io.o_data       = s1_rx_q;
        bus_io.o_data_valid = s1_valid_q;
        bus_io.o_ted        = ted_q;
        bus_io.o_ted_valid  = ted_valid_q;
        bus_io.o_sat        = sat_q;
    end
endmodule
